// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data memory with fixed wait states, one request in flight, stall generation
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_write;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_resp_valid;
  logic [31:0]   r_resp_rdata;
  logic          r_resp_err;
  logic [31:0]   r_mem [DEPTH_WORDS];
  logic          w_enter_resp;
  logic          w_acc_write;
  logic [31:0]   w_acc_addr;
  logic [31:0]   w_acc_wdata;
  logic [AW-1:0] w_idx;
  logic          w_fault;
  // With zero wait states the access happens on the accept edge, so it must use the live inputs
  assign w_enter_resp = (r_state == IDLE && req_valid && WAIT_CYCLES == 0) || (r_state == WAIT && r_cnt == 4'd1);
  assign w_acc_write  = (r_state == IDLE) ? req_write : r_write;
  assign w_acc_addr   = (r_state == IDLE) ? req_addr : r_addr;
  assign w_acc_wdata  = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_idx        = w_acc_addr[AW+1:2];
  assign w_fault      = (w_acc_addr[1:0] != 2'b00) || ((w_acc_addr >> (AW + 2)) != 32'd0);
  assign req_ready    = r_state == IDLE;
  assign stall        = r_state == WAIT || (r_state == IDLE && req_valid);
  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = r_resp_rdata;
  assign resp_err     = r_resp_err;
  // Store commits on the edge entering RESP; a reset on that same edge cancels it
  always_ff @(posedge clk)
    if (!rst && w_enter_resp && w_acc_write && !w_fault) r_mem[w_idx] <= w_acc_wdata;
  // Request FSM: latch on accept, count wait states, register the response on entering RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= w_enter_resp;
      if (w_enter_resp) begin
        r_resp_err   <= w_fault;
        r_resp_rdata <= (w_acc_write || w_fault) ? 32'd0 : r_mem[w_idx];
      end
      case (r_state)
        IDLE: if (req_valid) begin
          r_write <= req_write;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_cnt   <= 4'(WAIT_CYCLES);
          r_state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
        WAIT: if (r_cnt == 4'd1) r_state <= RESP;
              else r_cnt <= r_cnt - 4'd1;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench over three wait-state configurations with a timing/memory reference model
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int NI = 3;
  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    int          c;
  } req_t;
  logic clk = 1'b0;
  int n_pass = 0;
  int n_tot = 0;
  int done = 0;
  always #5 clk = ~clk;
  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endfunction
  function automatic logic fault(logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
  endfunction
  for (genvar k = 0; k < NI; k++) begin : g
    localparam int WC = (k == 0) ? 2 : (k == 1) ? 0 : 1;
    logic rst, req_valid, req_write, req_ready, resp_valid, resp_err, stall;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [31:0] mdl [16];
    req_t q[$];
    int rlog[$];
    int cyc = 0;
    int acc = -1000;
    int n_resp = 0;
    bit armed = 1'b0;
    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .stall(stall)
    );
    // Reference timing: a request accepted in cycle c occupies cycles c+1..c+WC+1, the last being the response
    always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
        acc <= -1000;
        q.delete();
      end else if (req_valid && cyc > acc + WC + 1) begin
        acc <= cyc;
        q.push_back('{req_write, req_addr, req_wdata, cyc});
      end
    end
    // Monitor: handshake/stall every cycle, and pop-and-compare on each response strobe
    always @(negedge clk) if (armed) begin
      check($sformatf("wc%0d req_ready", WC), 32'(req_ready), 32'(!(cyc > acc && cyc <= acc + WC + 1)));
      check($sformatf("wc%0d stall", WC), 32'(stall),
            32'((cyc > acc && cyc <= acc + WC) || (!(cyc > acc && cyc <= acc + WC + 1) && req_valid)));
      check($sformatf("wc%0d resp_valid", WC), 32'(resp_valid), 32'(cyc == acc + WC + 1));
      if (resp_valid) begin
        n_resp <= n_resp + 1;
        rlog.push_back(cyc);
      end
      if (resp_valid && q.size() != 0) begin : pop
        automatic req_t e = q.pop_front();
        automatic logic f = fault(e.a);
        check($sformatf("wc%0d latency %h", WC, e.a), 32'(cyc - e.c), 32'(WC + 1));
        check($sformatf("wc%0d resp_err %h", WC, e.a), 32'(resp_err), 32'(f));
        check($sformatf("wc%0d resp_rdata %h", WC, e.a), resp_rdata, (e.w || f) ? 32'd0 : mdl[e.a[5:2]]);
        if (e.w && !f) mdl[e.a[5:2]] <= e.d;
      end
    end
    task automatic step();
      @(posedge clk);
      #1;
    endtask
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input bit hold);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      while (cyc <= acc + WC + 1) step();
      step();
      if (!hold) req_valid = 1'b0;
    endtask
    task automatic drain();
      for (int t = 0; t < 50 && q.size() != 0; t++) step();
    endtask
    initial begin
      int base;
      int r;
      logic [31:0] a;
      rst = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      step();
      armed = 1'b1;
      step();
      check($sformatf("wc%0d reset resp_valid", WC), 32'(resp_valid), 32'd0);
      check($sformatf("wc%0d reset resp_rdata", WC), resp_rdata, 32'd0);
      check($sformatf("wc%0d reset resp_err", WC), 32'(resp_err), 32'd0);
      check($sformatf("wc%0d reset req_ready", WC), 32'(req_ready), 32'd1);
      check($sformatf("wc%0d reset stall", WC), 32'(stall), 32'd0);
      rst = 1'b0;
      step();
      for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), $urandom, 1'b0);
      issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
      issue(1'b0, 32'h10, 32'h0, 1'b0);
      issue(1'b1, 32'h4, 32'h12345678, 1'b0);
      issue(1'b0, 32'h4, 32'h0, 1'b0);
      issue(1'b1, 32'h6, 32'hFFFFFFFF, 1'b0);
      issue(1'b0, 32'h4, 32'h0, 1'b0);
      issue(1'b0, 32'h1000, 32'h0, 1'b0);
      if (WC != 0) begin
        issue(1'b1, 32'h20, 32'hAAAA5555, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        issue(1'b0, 32'h20, 32'h0, 1'b0);
      end
      drain();
      base = n_resp;
      rlog.delete();
      for (int i = 0; i < 3; i++) issue(1'b1, 32'h30 + 32'(i * 4), $urandom, 1'b1);
      req_valid = 1'b0;
      drain();
      step();
      check($sformatf("wc%0d held responses", WC), 32'(n_resp - base), 32'd3);
      check($sformatf("wc%0d held spacing 1", WC), 32'(rlog[1] - rlog[0]), 32'(WC + 2));
      check($sformatf("wc%0d held spacing 2", WC), 32'(rlog[2] - rlog[1]), 32'(WC + 2));
      for (int i = 0; i < 150; i++) begin
        r = $urandom_range(0, 9);
        a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
        else if (r == 1) a = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
        else if (r == 2) a = {1'b1, 31'($urandom)} & 32'hFFFFFFFC;
        issue(1'($urandom_range(0, 1)), a, $urandom, 1'b0);
        repeat ($urandom_range(0, 2)) step();
      end
      drain();
      check($sformatf("wc%0d outstanding after drain", WC), 32'(q.size()), 32'd0);
      done++;
    end
  end
  initial begin
    for (int t = 0; t < 80000 && done < NI; t++) @(posedge clk);
    check("all instances finished", 32'(done), 32'(NI));
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
